// File: rtl/fxp_alu_gen2.sv
// fxp_alu_gen2: second-generation fixed-point ALU (add/sub/MAC/gray/rotate/clz/abs, optional matrix transpose)
//   Optional feature macro: FXP_ALU_GEN2_MATRIX_EN (opcode 1000 = MAT_N x MAT_N transpose)
//   Ports:
//     i_clk, i_rst_n        clock (rising edge), asynchronous active-low reset
//     i_in_valid / o_busy   instruction handshake; inputs are dropped while o_busy=1
//     i_inst                opcode
//     i_data_a, i_data_b    signed Q(INT_W).(FRAC_W) operands; i_data_a is a matrix row for 1000
//     o_out_valid           o_data/o_sat valid this cycle
//     o_data, o_sat         result and clamp flag; both hold while o_out_valid=0
module fxp_alu_gen2 #(
    parameter int INST_W = 4,
    parameter int INT_W  = 6,
    parameter int FRAC_W = 10,
    parameter int DATA_W = INT_W + FRAC_W,
    parameter int ACC_W  = 2 * DATA_W + 4,
    parameter int MAT_N  = 8,
    parameter int ELEM_W = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_in_valid,
    output logic              o_busy,
    input  logic [INST_W-1:0] i_inst,
    input  logic [DATA_W-1:0] i_data_a,
    input  logic [DATA_W-1:0] i_data_b,
    output logic              o_out_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_sat
);
    localparam int SH_W  = $clog2(DATA_W);
    localparam int CLZ_W = $clog2(DATA_W + 1);
    localparam int Q_W   = ACC_W - FRAC_W + 1;
    localparam logic [DATA_W-1:0] D_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] D_MIN = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [ACC_W-1:0]  A_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0]  A_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [ACC_W:0] HALF = {{(ACC_W-FRAC_W+1){1'b0}}, 1'b1, {(FRAC_W-1){1'b0}}};

    typedef enum logic [1:0] {LOAD, CALC, OUT} state_t;
    state_t state, state_n;

    logic [INST_W-1:0]        op;
    logic signed [DATA_W-1:0] a, b;
    logic signed [ACC_W-1:0]  acc, acc_mac;
    logic signed [DATA_W:0]   sum, diff;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W:0]    acc_sum;
    logic signed [Q_W-1:0]    q;
    logic                     acc_ovf, q_ovf, res_sat, accept, hold, done, mat_sel;
    logic                     busy_n, valid_n, sat_n;
    logic [CLZ_W-1:0]         clz;
    logic [DATA_W-1:0]        res, row_out, data_n;

    assign accept  = i_in_valid && !o_busy;
    assign sum     = (DATA_W+1)'(a) + (DATA_W+1)'(b);
    assign diff    = (DATA_W+1)'(a) - (DATA_W+1)'(b);
    assign prod    = (2*DATA_W)'(a) * (2*DATA_W)'(b);
    assign acc_sum = (ACC_W+1)'(acc) + (ACC_W+1)'(prod);
    assign acc_ovf = acc_sum[ACC_W] != acc_sum[ACC_W-1];
    assign acc_mac = acc_ovf ? (acc_sum[ACC_W] ? A_MIN : A_MAX) : acc_sum[ACC_W-1:0];
    // Round half-up on the new accumulator, then drop the extra fraction bits.
    assign q       = Q_W'(((ACC_W+1)'(acc_mac) + HALF) >>> FRAC_W);
    assign q_ovf   = q[Q_W-1:DATA_W-1] != {(Q_W-DATA_W+1){q[Q_W-1]}};

    always_comb begin
        clz = CLZ_W'(DATA_W);
        for (int i = 0; i < DATA_W; i++)
            if (a[i]) clz = CLZ_W'(DATA_W - 1 - i);
        res     = '0;
        res_sat = 1'b0;
        case (op)
            INST_W'(0): begin
                res_sat = sum[DATA_W] != sum[DATA_W-1];
                res     = res_sat ? (sum[DATA_W] ? D_MIN : D_MAX) : sum[DATA_W-1:0];
            end
            INST_W'(1): begin
                res_sat = diff[DATA_W] != diff[DATA_W-1];
                res     = res_sat ? (diff[DATA_W] ? D_MIN : D_MAX) : diff[DATA_W-1:0];
            end
            INST_W'(2): begin
                res_sat = acc_ovf || q_ovf;
                res     = q_ovf ? (q[Q_W-1] ? D_MIN : D_MAX) : q[DATA_W-1:0];
            end
            INST_W'(4): res = {a[DATA_W-1], a[DATA_W-1:1] ^ a[DATA_W-2:0]};
            INST_W'(5): res = DATA_W'({a, a} >> b[SH_W-1:0]);
            INST_W'(6): res = DATA_W'(clz);
            INST_W'(7): begin
                res_sat = a == D_MIN;
                res     = res_sat ? D_MAX : (a[DATA_W-1] ? -a : a);
            end
            default: ;
        endcase
    end

`ifdef FXP_ALU_GEN2_MATRIX_EN
    localparam int MI = $clog2(MAT_N);
    logic [DATA_W-1:0] rows [MAT_N];
    logic [MI-1:0]     cnt;
    logic [MI:0]       idx;
    logic              load_row, last_row;

    assign load_row = accept && i_inst == INST_W'(8);
    assign last_row = load_row && cnt == MI'(MAT_N - 1);
    // Rows 0..MAT_N-2 are absorbed without leaving LOAD.
    assign hold     = load_row && !last_row;
    assign mat_sel  = op == INST_W'(8);
    assign done     = !mat_sel || idx == (MI+1)'(MAT_N);

    // Output row idx gathers element idx from every stored row.
    always_comb begin
        row_out = '0;
        for (int c = 0; c < MAT_N; c++)
            row_out[DATA_W-1-c*ELEM_W -: ELEM_W] = rows[c][DATA_W-1-int'(idx[MI-1:0])*ELEM_W -: ELEM_W];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rows <= '{default: '0};
            cnt  <= '0;
            idx  <= '0;
        end else begin
            if (load_row) begin
                rows[cnt] <= i_data_a;
                cnt       <= last_row ? '0 : cnt + 1'b1;
            end else if (accept) cnt <= '0;
            if (last_row) idx <= '0;
            else if (state != LOAD && !done) idx <= idx + 1'b1;
        end
    end
`else
    assign hold    = 1'b0;
    assign mat_sel = 1'b0;
    assign done    = 1'b1;
    assign row_out = '0;
`endif

    always_comb begin
        state_n = state;
        busy_n  = o_busy;
        valid_n = 1'b0;
        data_n  = o_data;
        sat_n   = o_sat;
        case (state)
            LOAD: if (accept && !hold) begin
                state_n = CALC;
                busy_n  = 1'b1;
            end
            CALC: begin
                state_n = OUT;
                valid_n = 1'b1;
                data_n  = mat_sel ? row_out : res;
                sat_n   = res_sat;
            end
            OUT: if (done) begin
                state_n = LOAD;
                busy_n  = 1'b0;
            end else begin
                valid_n = 1'b1;
                data_n  = row_out;
                sat_n   = 1'b0;
            end
            default: state_n = LOAD;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= LOAD;
        else state <= state_n;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_busy      <= 1'b0;
            o_out_valid <= 1'b0;
            o_data      <= '0;
            o_sat       <= 1'b0;
            acc         <= '0;
            op          <= '0;
            a           <= '0;
            b           <= '0;
        end else begin
            o_busy      <= busy_n;
            o_out_valid <= valid_n;
            o_data      <= data_n;
            o_sat       <= sat_n;
            if (accept) begin
                op <= i_inst;
                a  <= i_data_a;
                b  <= i_data_b;
            end
            if (state == CALC && op == INST_W'(2)) acc <= acc_mac;
            if (state == CALC && op == INST_W'(3)) acc <= '0;
        end
    end
endmodule

// File: tb/tb_fxp_alu_gen2.sv
// tb_fxp_alu_gen2: self-checking bench for fxp_alu_gen2 (vector table, random ops vs reference model, matrix sequences)
module tb_fxp_alu_gen2;
    logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0;
    logic        busy, out_valid, sat;
    logic [3:0]  inst = '0;
    logic [15:0] data_a = '0, data_b = '0, data;
    int          checks = 0, errors = 0;
    longint      macc = 0;
    localparam longint AMAX = 64'sd34359738367;
    localparam longint AMIN = -64'sd34359738368;

    typedef struct packed {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] d;
        logic        s;
    } vec_t;
    vec_t vt [$];

`ifdef FXP_ALU_GEN2_MATRIX_EN
    logic [15:0] mrow [8];
    logic [15:0] mgot [8];
`endif

    fxp_alu_gen2 dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_in_valid  (in_valid),
        .o_busy      (busy),
        .i_inst      (inst),
        .i_data_a    (data_a),
        .i_data_b    (data_b),
        .o_out_valid (out_valid),
        .o_data      (data),
        .o_sat       (sat)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] clamp16(input longint r, output logic hit);
        hit = r > 32767 || r < -32768;
        return r > 32767 ? 16'h7FFF : (r < -32768 ? 16'h8000 : 16'(r));
    endfunction

    // Reference: plain integer arithmetic on real values of the Q6.10 operands.
    function automatic void model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] d, output logic s);
        longint x, y;
        logic   h;
        int     n;
        logic   found;
        x = longint'($signed(a));
        y = longint'($signed(b));
        d = '0;
        s = 1'b0;
        case (op)
            4'd0: d = clamp16(x + y, s);
            4'd1: d = clamp16(x - y, s);
            4'd2: begin
                macc = macc + x * y;
                if (macc > AMAX) begin macc = AMAX; s = 1'b1; end
                else if (macc < AMIN) begin macc = AMIN; s = 1'b1; end
                d = clamp16((macc + 512) >>> 10, h);
                s = s | h;
            end
            4'd3: macc = 0;
            4'd4: d = a ^ (a >> 1);
            4'd5: begin
                n = int'(b[3:0]);
                for (int k = 0; k < 16; k++) d[k] = a[(k + n) % 16];
            end
            4'd6: begin
                d = 16'd16;
                found = 1'b0;
                for (int k = 15; k >= 0; k--)
                    if (a[k] && !found) begin d = 16'(15 - k); found = 1'b1; end
            end
            4'd7: d = clamp16(x < 0 ? -x : x, s);
            default: ;
        endcase
    endfunction

    function automatic logic [15:0] rnd16();
        int k = $urandom_range(0, 7);
        return k == 0 ? 16'h7FFF : k == 1 ? 16'h8000 : k == 2 ? 16'($urandom_range(0, 2047)) : 16'($urandom);
    endfunction

    // Issues one scalar op; returns result, edges-to-valid and busy-high sample count.
    task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                          output logic [15:0] d, output logic s, output int lat, output int bhi);
        int w = 0;
        while (busy && w < 50) begin @(negedge clk); w++; end
        if (w == 50) check("busy_stuck", busy, 0);
        inst = op; data_a = a; data_b = b; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        bhi = int'(busy);
        while (!out_valid && lat < 20) begin @(negedge clk); lat++; bhi += int'(busy); end
        d = data;
        s = sat;
        @(negedge clk);
        bhi += int'(busy);
    endtask

`ifdef FXP_ALU_GEN2_MATRIX_EN
    task automatic feed_rows(input int n, output int early);
        early = 0;
        for (int r = 0; r < n; r++) begin
            inst = 4'b1000; data_a = mrow[r]; data_b = 16'($urandom); in_valid = 1'b1;
            @(negedge clk);
            if (r < 7) early += int'(busy);
        end
        in_valid = 1'b0;
    endtask

    task automatic read_rows(output int n, output int first, output int last);
        n = 0; first = -1; last = -1;
        for (int r = 0; r < 8; r++) mgot[r] = '0;
        for (int t = 1; t <= 16; t++) begin
            if (out_valid) begin
                if (first < 0) first = t;
                last = t;
                if (n < 8) mgot[n] = data;
                n++;
            end
            @(negedge clk);
        end
    endtask

    function automatic logic [15:0] tr_row(input int r);
        logic [15:0] w = '0;
        for (int c = 0; c < 8; c++) begin
            logic [1:0] e;
            e = 2'(mrow[c] >> (14 - 2 * r));
            w = w | (16'(e) << (14 - 2 * c));
        end
        return w;
    endfunction
`endif

    initial begin
        logic [15:0] d, md;
        logic        s, ms;
        int          lat, bhi;
`ifdef FXP_ALU_GEN2_MATRIX_EN
        int          early, n, first, last;
`endif
        vt.push_back({4'h0, 16'h7000, 16'h2000, 16'h7FFF, 1'b1});
        vt.push_back({4'h0, 16'h0100, 16'h0200, 16'h0300, 1'b0});
        vt.push_back({4'h1, 16'h8000, 16'h0001, 16'h8000, 1'b1});
        vt.push_back({4'h1, 16'h0400, 16'h0C00, 16'hF800, 1'b0});
        vt.push_back({4'h2, 16'h0400, 16'h0600, 16'h0600, 1'b0});
        vt.push_back({4'h2, 16'h0400, 16'h0600, 16'h0C00, 1'b0});
        vt.push_back({4'h3, 16'h1234, 16'h5678, 16'h0000, 1'b0});
        vt.push_back({4'h2, 16'h0400, 16'h0400, 16'h0400, 1'b0});
        vt.push_back({4'h5, 16'h0001, 16'h0001, 16'h8000, 1'b0});
        vt.push_back({4'h5, 16'h1234, 16'h0010, 16'h1234, 1'b0});
        vt.push_back({4'h6, 16'h00F0, 16'h0000, 16'h0008, 1'b0});
        vt.push_back({4'h6, 16'h0000, 16'h0000, 16'h0010, 1'b0});
        vt.push_back({4'h7, 16'h8000, 16'h0000, 16'h7FFF, 1'b1});
        vt.push_back({4'h7, 16'hFC00, 16'h0000, 16'h0400, 1'b0});
        vt.push_back({4'h4, 16'h8001, 16'h0000, 16'hC001, 1'b0});
        vt.push_back({4'hF, 16'h7FFF, 16'h7FFF, 16'h0000, 1'b0});
`ifndef FXP_ALU_GEN2_MATRIX_EN
        vt.push_back({4'h8, 16'hFFFF, 16'h1234, 16'h0000, 1'b0});
`endif

        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_valid", out_valid, 0);
        check("rst_data", data, 0);
        check("rst_sat", sat, 0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vt[i]) begin
            run_op(vt[i].op, vt[i].a, vt[i].b, d, s, lat, bhi);
            model(vt[i].op, vt[i].a, vt[i].b, md, ms);
            check($sformatf("vec%0d_data", i), d, vt[i].d);
            check($sformatf("vec%0d_sat", i), s, vt[i].s);
            check($sformatf("vec%0d_latency", i), lat, 2);
            check($sformatf("vec%0d_busy_cycles", i), bhi, 2);
            check($sformatf("vec%0d_hold", i), data, vt[i].d);
        end

        run_op(4'h3, 16'h0, 16'h0, d, s, lat, bhi);
        model(4'h3, 16'h0, 16'h0, md, ms);
        check("macsat_clear", d, md);
        for (int i = 0; i < 74; i++) begin
            logic [15:0] bb;
            bb = i < 40 ? 16'h8000 : 16'h7FFF;
            run_op(4'h2, 16'h8000, bb, d, s, lat, bhi);
            model(4'h2, 16'h8000, bb, md, ms);
            check($sformatf("macsat%0d_data", i), d, md);
            check($sformatf("macsat%0d_sat", i), s, ms);
        end

        for (int i = 0; i < 250; i++) begin
            logic [3:0]  op;
            logic [15:0] a, b;
            op = 4'($urandom_range(0, 15));
`ifdef FXP_ALU_GEN2_MATRIX_EN
            if (op == 4'h8) op = 4'h9;
`endif
            a = rnd16();
            b = rnd16();
            run_op(op, a, b, d, s, lat, bhi);
            model(op, a, b, md, ms);
            check($sformatf("rnd%0d_op%0d_data", i, op), d, md);
            check($sformatf("rnd%0d_op%0d_sat", i, op), s, ms);
            check($sformatf("rnd%0d_latency", i), lat, 2);
        end

`ifdef FXP_ALU_GEN2_MATRIX_EN
        for (int c = 0; c < 8; c++) begin
            logic [1:0] e;
            e = 2'(c % 4);
            mrow[c] = {8{e}};
        end
        feed_rows(8, early);
        check("mat_busy_early", early, 0);
        check("mat_busy_row7", busy, 1);
        read_rows(n, first, last);
        check("mat_valid_count", n, 8);
        check("mat_first_latency", first, 2);
        check("mat_contiguous", last - first, 7);
        for (int r = 0; r < 8; r++) check($sformatf("mat_row%0d", r), mgot[r], 16'h1B1B);
        check("mat_busy_after", busy, 0);

        for (int c = 0; c < 3; c++) mrow[c] = 16'($urandom);
        feed_rows(3, early);
        check("abort_busy_partial", early, 0);
        run_op(4'h0, 16'h0400, 16'h0400, d, s, lat, bhi);
        check("abort_add_data", d, 16'h0800);
        check("abort_add_sat", s, 0);
        check("abort_add_latency", lat, 2);
        for (int c = 0; c < 8; c++) mrow[c] = 16'($urandom);
        feed_rows(8, early);
        check("fresh_busy_early", early, 0);
        check("fresh_busy_row7", busy, 1);
        read_rows(n, first, last);
        check("fresh_valid_count", n, 8);
        for (int r = 0; r < 8; r++) check($sformatf("fresh_row%0d", r), mgot[r], tr_row(r));
`endif

        run_op(4'h2, 16'h0400, 16'h0400, d, s, lat, bhi);
        model(4'h2, 16'h0400, 16'h0400, md, ms);
        check("pre_reset_mac", d, md);
`ifdef FXP_ALU_GEN2_MATRIX_EN
        for (int c = 0; c < 8; c++) begin
            logic [1:0] e;
            e = 2'(c % 4);
            mrow[c] = {8{e}};
        end
        feed_rows(8, early);
        repeat (3) @(negedge clk);
`else
        inst = 4'h2; data_a = 16'h0400; data_b = 16'h0400; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
`endif
        check("pre_reset_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_valid", out_valid, 0);
        check("arst_data", data, 0);
        check("arst_sat", sat, 0);
        macc = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(4'h2, 16'h0400, 16'h0400, d, s, lat, bhi);
        model(4'h2, 16'h0400, 16'h0400, md, ms);
        check("post_reset_mac_data", d, 16'h0400);
        check("post_reset_mac_sat", s, 0);
        check("post_reset_mac_latency", lat, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
